// File: rtl/mod60_down_timer_pkg.sv
// Shared definitions for the mod-60 BCD down timer: state encoding, digit limits,
// the two-digit value payload and a digit clamp helper.
package mod60_down_timer_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    localparam logic [DIGIT_W-1:0] UNITS_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] TENS_MAX  = 4'd5;

    typedef struct packed {
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] units;
    } bcd_val_t;

    // Saturate an out-of-range BCD load digit to the digit's maximum.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                       input logic [DIGIT_W-1:0] max_v);
        return (d > max_v) ? max_v : d;
    endfunction

endpackage

// File: rtl/mod60_down_timer_if.sv
// Control/load/display signal bundle of the mod-60 down timer.
interface mod60_down_timer_if;
    import mod60_down_timer_pkg::*;

    logic               CE;
    logic               load;
    logic [DIGIT_W-1:0] LD0;
    logic [DIGIT_W-1:0] LD1;
    logic               start;
    logic               stop;
    logic [DIGIT_W-1:0] D0;
    logic [DIGIT_W-1:0] D1;
    logic               BO1;
    logic               TC;
    logic               BUSY;
    logic               DONE;

    modport master (
        output CE, load, LD0, LD1, start, stop,
        input  D0, D1, BO1, TC, BUSY, DONE
    );

    modport slave (
        input  CE, load, LD0, LD1, start, stop,
        output D0, D1, BO1, TC, BUSY, DONE
    );

endinterface

// File: rtl/mod60_down_timer_dec_bcd_digit.sv
// Loadable single BCD digit down-counter; wraps 0 -> max_val on borrow, load wins.
module dec_bcd_digit
    import mod60_down_timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic [DIGIT_W-1:0] max_val,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_en) begin
            digit_d = load_val;
        end else if (borrow_in) begin
            digit_d = (digit_q == '0) ? max_val : digit_q - DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q          = digit_q;
    assign borrow_out = borrow_in & (digit_q == '0);

endmodule

// File: rtl/mod60_down_timer.sv
// Mod-60 BCD down timer with IDLE/RUN/DONE control and load clamping.
// Define MOD60_DOWN_TIMER_AUTO_RELOAD_EN to reload and keep running on expiry.
module mod60_down_timer
    import mod60_down_timer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    mod60_down_timer_if.slave   bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    bcd_val_t           reload_q;
    bcd_val_t           reload_d;
    logic               tc_q;
    logic               tc_d;

    bcd_val_t           load_clamped;
    bcd_val_t           digit_load_val;
    logic               running;
    logic               stop_hit;
    logic               count_cycle;
    logic               units_borrow;
    logic               expire;
    logic               digit_load;
    logic [DIGIT_W-1:0] units_q;
    logic [DIGIT_W-1:0] tens_q;

    assign load_clamped.tens  = clamp_digit(bus.LD1, TENS_MAX);
    assign load_clamped.units = clamp_digit(bus.LD0, UNITS_MAX);

    assign running     = (state_q == ST_RUN);
    assign stop_hit    = running & bus.stop;
    assign count_cycle = running & bus.CE & ~bus.load & ~stop_hit;

    // A borrow out of the tens digit means the count was already 00: that is expiry.
    // The digit load then overrides the wrap to 59 with either the reload value or 00.
    assign digit_load = bus.load | expire;

    always_comb begin
        digit_load_val = '0;
        if (bus.load) begin
            digit_load_val = load_clamped;
        end else begin
`ifdef MOD60_DOWN_TIMER_AUTO_RELOAD_EN
            digit_load_val = reload_q;
`else
            digit_load_val = '0;
`endif
        end
    end

    dec_bcd_digit u_units (
        .clk        (clk),
        .reset      (reset),
        .load_en    (digit_load),
        .load_val   (digit_load_val.units),
        .max_val    (UNITS_MAX),
        .borrow_in  (count_cycle),
        .q          (units_q),
        .borrow_out (units_borrow)
    );

    dec_bcd_digit u_tens (
        .clk        (clk),
        .reset      (reset),
        .load_en    (digit_load),
        .load_val   (digit_load_val.tens),
        .max_val    (TENS_MAX),
        .borrow_in  (units_borrow),
        .q          (tens_q),
        .borrow_out (expire)
    );

    // Next-state: load > stop > start > count.
    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (bus.load) begin
            state_d  = ST_IDLE;
            reload_d = load_clamped;
        end else if (stop_hit) begin
            state_d = ST_IDLE;
        end else if (bus.start && !running) begin
            state_d = ST_RUN;
        end else if (expire) begin
            tc_d = 1'b1;
`ifdef MOD60_DOWN_TIMER_AUTO_RELOAD_EN
            state_d = ST_RUN;
`else
            state_d = ST_DONE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign bus.D0   = units_q;
    assign bus.D1   = tens_q;
    assign bus.TC   = tc_q;
    assign bus.BUSY = running;
    assign bus.DONE = (state_q == ST_DONE);
    assign bus.BO1  = bus.CE & running & (units_q == '0);

endmodule

// File: tb/tb_mod60_down_timer.sv
// Self-checking bench for mod60_down_timer: directed vector table, corner sequences,
// and randomized traffic against an integer reference model.
module tb_mod60_down_timer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mod60_down_timer_if bus ();

    mod60_down_timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    // Reference model: value held as a plain integer 0..59.
    int m_val = 0;
    int m_rl  = 0;
    int m_st  = M_IDLE;
    int m_tc  = 0;

    typedef struct {
        bit       r;
        bit       ld;
        bit [3:0] l1;
        bit [3:0] l0;
        bit       s;
        bit       sp;
        bit       ce;
        bit       exp_bo1;
        int       exp_val;
        bit       exp_busy;
        bit       exp_done;
        bit       exp_tc;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit ld, input bit [3:0] l1, input bit [3:0] l0,
                         input bit s, input bit sp, input bit ce);
        @(negedge clk);
        reset     = r;
        bus.load  = ld;
        bus.LD1   = l1;
        bus.LD0   = l0;
        bus.start = s;
        bus.stop  = sp;
        bus.CE    = ce;
        #1;
    endtask

    function automatic void model_step();
        int t;
        int u;
        if (reset) begin
            m_val = 0; m_rl = 0; m_st = M_IDLE; m_tc = 0;
            return;
        end
        m_tc = 0;
        if (bus.load) begin
            t = (bus.LD1 > 5) ? 5 : int'(bus.LD1);
            u = (bus.LD0 > 9) ? 9 : int'(bus.LD0);
            m_val = t * 10 + u;
            m_rl  = m_val;
            m_st  = M_IDLE;
        end else if (bus.stop && m_st == M_RUN) begin
            m_st = M_IDLE;
        end else if (bus.start && m_st != M_RUN) begin
            m_st = M_RUN;
        end else if (m_st == M_RUN && bus.CE) begin
            if (m_val == 0) begin
                m_tc = 1;
`ifdef MOD60_DOWN_TIMER_AUTO_RELOAD_EN
                m_val = m_rl;
`else
                m_st = M_DONE;
`endif
            end else begin
                m_val = m_val - 1;
            end
        end
    endfunction

    function automatic bit model_bo1();
        return bus.CE && (m_st == M_RUN) && (m_val % 10 == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_state(input string tag, input int val, input bit busy,
                               input bit done, input bit tc);
        check({tag, "_d1"},   32'(bus.D1), 32'(val / 10));
        check({tag, "_d0"},   32'(bus.D0), 32'(val % 10));
        check({tag, "_busy"}, 32'(bus.BUSY), 32'(busy));
        check({tag, "_done"}, 32'(bus.DONE), 32'(done));
        check({tag, "_tc"},   32'(bus.TC), 32'(tc));
    endtask

    initial begin
        reset = 1'b1; bus.load = 1'b0; bus.LD1 = '0; bus.LD0 = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.CE = 1'b0;

        //            r ld l1 l0 s sp ce bo1 val busy done tc
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        vecs[1]  = '{0, 1, 2, 0, 0, 0, 0, 0, 20, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 1, 0, 0, 0, 20, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 1, 1, 19, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 1, 0, 1, 0, 18, 1, 0, 0};
        vecs[5]  = '{0, 1, 7, 12, 0, 0, 0, 0, 59, 0, 0, 0};
        vecs[6]  = '{0, 1, 3, 5, 0, 0, 0, 0, 35, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 1, 0, 0, 0, 35, 1, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 1, 1, 0, 35, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 35, 0, 0, 0};
        vecs[10] = '{0, 1, 4, 2, 1, 0, 0, 0, 42, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 42, 1, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0};
        vecs[13] = '{0, 1, 6, 3, 0, 0, 0, 0, 53, 0, 0, 0};
        vecs[14] = '{0, 1, 1, 15, 0, 0, 0, 0, 19, 0, 0, 0};
        vecs[15] = '{0, 0, 0, 0, 1, 1, 0, 0, 19, 1, 0, 0};

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].r, vecs[i].ld, vecs[i].l1, vecs[i].l0,
                  vecs[i].s, vecs[i].sp, vecs[i].ce);
            check($sformatf("vec%0d_bo1", i), 32'(bus.BO1), 32'(vecs[i].exp_bo1));
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].exp_val, vecs[i].exp_busy,
                        vecs[i].exp_done, vecs[i].exp_tc);
        end

        // Expiry from 01.
        drive(0, 1, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        check("exp_bo1_first", 32'(bus.BO1), 32'd0);
        tick();
        check_state("exp_first", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("exp_bo1_zero", 32'(bus.BO1), 32'd1);
        tick();
`ifdef MOD60_DOWN_TIMER_AUTO_RELOAD_EN
        check_state("exp_hit", 1, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        check_state("exp_after", 0, 1, 0, 0);
`else
        check_state("exp_hit", 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        check_state("exp_after", 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 0); tick();
        check_state("exp_restart", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        check_state("exp_again", 0, 0, 1, 1);
`endif

        // Full 60-step countdown from a clamped 59.
        drive(0, 1, 7, 12, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0, 0); tick();
        for (int i = 1; i <= 59; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1); tick();
            check_state($sformatf("cnt%0d", i), 59 - i, 1, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 1); tick();
`ifdef MOD60_DOWN_TIMER_AUTO_RELOAD_EN
        check_state("cnt_expire", 59, 1, 0, 1);
`else
        check_state("cnt_expire", 0, 0, 1, 1);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 2) != 0);
            check("rand_bo1", 32'(bus.BO1), 32'(model_bo1()));
            tick();
            check_state("rand", m_val, m_st == M_RUN, m_st == M_DONE, m_tc[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
